// File: rtl/rvc_mem_loader.sv
// Byte-stream program loader: decodes LOAD/GO frames, writes words into core memory,
// and holds the core in reset until GO arrives.
module rvc_mem_loader #(
    parameter logic [31:0] MEM_MSB = 32'h1FFF
) (
    input  logic        Clock,
    input  logic        Rst,
    input  logic        RxValid,
    input  logic [7:0]  RxData,
    output logic        RxReady,
    output logic        MemWrEn,
    output logic [31:0] MemWrAddr,
    output logic [31:0] MemWrData,
    output logic [3:0]  MemWrByteEn,
    output logic        CoreRst,
    output logic        ErrFlag,
    output logic [15:0] WordCnt
);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LEN, S_DATA, S_RUN} state_t;

    state_t      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] shift_q, shift_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] rem_q, rem_d;
    logic        wr_en_q, wr_en_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        err_q, err_d;
    logic [15:0] word_cnt_q, word_cnt_d;
    logic        core_rst_q, core_rst_d;
    logic        rx_ready_q, rx_ready_d;

    logic        accept;
    logic [31:0] shifted;
    logic [32:0] last_byte;
    logic        fits;

    // Little-endian assembly: each new byte enters at the top, so the first byte lands in 7:0.
    assign accept    = RxValid && rx_ready_q;
    assign shifted   = {RxData, shift_q[31:8]};
    assign last_byte = {1'b0, addr_q} + 33'd3;
    assign fits      = (last_byte <= {1'b0, MEM_MSB});

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        err_d      = err_q;
        word_cnt_d = word_cnt_q;

        if (accept) begin
            case (state_q)
                S_IDLE: begin
                    byte_cnt_d = 2'd0;
                    if (RxData == 8'h4C)      state_d = S_ADDR;
                    else if (RxData == 8'h47) state_d = S_RUN;
                    else                      err_d   = 1'b1;
                end
                S_ADDR: begin
                    shift_d    = shifted;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        addr_d     = {shifted[31:2], 2'b00};
                        byte_cnt_d = 2'd0;
                        state_d    = S_LEN;
                        if (shifted[1:0] != 2'b00) err_d = 1'b1;
                    end
                end
                S_LEN: begin
                    shift_d    = shifted;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd1) begin
                        rem_d      = shifted[31:16];
                        byte_cnt_d = 2'd0;
                        state_d    = (shifted[31:16] == 16'd0) ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    shift_d    = shifted;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        byte_cnt_d = 2'd0;
                        // Out-of-range words are dropped but the frame keeps consuming its bytes.
                        if (fits) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = addr_q;
                            wr_data_d = shifted;
                            if (word_cnt_q != 16'hFFFF) word_cnt_d = word_cnt_q + 16'd1;
                        end else begin
                            err_d = 1'b1;
                        end
                        addr_d = addr_q + 32'd4;
                        rem_d  = rem_q - 16'd1;
                        if (rem_q == 16'd1) state_d = S_IDLE;
                    end
                end
                default: ;
            endcase
        end

        rx_ready_d = (state_d != S_RUN);
        core_rst_d = (state_d != S_RUN);
    end

    always_ff @(posedge Clock) begin
        if (Rst) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= 2'd0;
            shift_q    <= 32'd0;
            addr_q     <= 32'd0;
            rem_q      <= 16'd0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= 32'd0;
            wr_data_q  <= 32'd0;
            err_q      <= 1'b0;
            word_cnt_q <= 16'd0;
            core_rst_q <= 1'b1;
            rx_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            err_q      <= err_d;
            word_cnt_q <= word_cnt_d;
            core_rst_q <= core_rst_d;
            rx_ready_q <= rx_ready_d;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_byte_en
            assign MemWrByteEn[gi] = wr_en_q;
        end
    endgenerate

    assign RxReady   = rx_ready_q;
    assign MemWrEn   = wr_en_q;
    assign MemWrAddr = wr_addr_q;
    assign MemWrData = wr_data_q;
    assign CoreRst   = core_rst_q;
    assign ErrFlag   = err_q;
    assign WordCnt   = word_cnt_q;

endmodule

// File: tb/tb_rvc_mem_loader.sv
// Directed bench for rvc_mem_loader: basic, throttled, boundary, protocol-error and reset cases.
module tb_rvc_mem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        core_rst;
    logic        err_flag;
    logic [15:0] word_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic [7:0]  fq[$];

    always #5 clk = ~clk;

    rvc_mem_loader #(.MEM_MSB(32'h1FFF)) dut (
        .Clock(clk), .Rst(rst), .RxValid(rx_valid), .RxData(rx_data), .RxReady(rx_ready),
        .MemWrEn(wr_en), .MemWrAddr(wr_addr), .MemWrData(wr_data), .MemWrByteEn(wr_be),
        .CoreRst(core_rst), .ErrFlag(err_flag), .WordCnt(word_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    // Every write strobe is logged; byte enables must be all-ones whenever the strobe is high.
    always @(negedge clk) begin
        if (wr_en) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
            chk("byte_en", {28'd0, wr_be}, 32'hF);
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit throttle);
        int guard;
        if (throttle) begin
            rx_valid = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
        end
        rx_valid = 1'b1;
        rx_data  = b;
        guard    = 0;
        while (!rx_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) chk("rx_ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic push_load(input logic [31:0] a, input logic [15:0] n);
        fq.push_back(8'h4C);
        for (int i = 0; i < 4; i++) fq.push_back(a[8*i +: 8]);
        fq.push_back(n[7:0]);
        fq.push_back(n[15:8]);
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) fq.push_back(w[8*i +: 8]);
    endtask

    task automatic send_fq(input bit throttle);
        for (int i = 0; i < fq.size(); i++) send_byte(fq[i], throttle);
        fq.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic chk_writes(input string tag, input int n, input logic [31:0] a0,
                              input logic [31:0] d0, input logic [31:0] a1, input logic [31:0] d1);
        chk({tag, "_count"}, wa_q.size(), n);
        if (n > 0 && wa_q.size() > 0) begin
            chk({tag, "_addr0"}, wa_q[0], a0);
            chk({tag, "_data0"}, wd_q[0], d0);
        end
        if (n > 1 && wa_q.size() > 1) begin
            chk({tag, "_addr1"}, wa_q[1], a1);
            chk({tag, "_data1"}, wd_q[1], d1);
        end
    endtask

    logic [7:0] basic [16];

    initial begin
        basic = '{8'h4C, 8'h00, 8'h10, 8'h00, 8'h00, 8'h02, 8'h00,
                  8'h13, 8'h00, 8'h00, 8'h00, 8'h73, 8'h00, 8'h10, 8'h00, 8'h47};
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;

        // Reset values while Rst is held
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rxready", rx_ready, 0);
        chk("rst_wren", wr_en, 0);
        chk("rst_addr", wr_addr, 0);
        chk("rst_data", wr_data, 0);
        chk("rst_be", wr_be, 0);
        chk("rst_corerst", core_rst, 1);
        chk("rst_err", err_flag, 0);
        chk("rst_wcnt", word_cnt, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rxready_after_rst", rx_ready, 1);

        // Basic load at full rate with inline timing checks
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("corerst_before_go", core_rst, 1);
            send_byte(basic[i], 1'b0);
            if (i == 9)  chk("no_early_wr", wr_en, 0);
            if (i == 10) begin
                chk("w0_en", wr_en, 1);
                chk("w0_addr", wr_addr, 32'h1000);
                chk("w0_data", wr_data, 32'h13);
                chk("w0_wcnt", word_cnt, 1);
            end
            if (i == 11) chk("w0_one_cycle", wr_en, 0);
            if (i == 14) begin
                chk("w1_en", wr_en, 1);
                chk("w1_addr", wr_addr, 32'h1004);
                chk("w1_data", wr_data, 32'h00100073);
            end
            if (i == 15) begin
                chk("go_corerst", core_rst, 0);
                chk("go_rxready", rx_ready, 0);
            end
        end
        rx_valid = 1'b1; rx_data = 8'h4C;
        repeat (3) @(posedge clk);
        #1;
        rx_valid = 1'b0;
        chk("run_rxready", rx_ready, 0);
        chk("run_corerst", core_rst, 0);
        chk("basic_wcnt", word_cnt, 2);
        chk("basic_err", err_flag, 0);
        chk_writes("basic", 2, 32'h1000, 32'h13, 32'h1004, 32'h00100073);

        // Throttled stream, same frame
        do_reset();
        for (int i = 0; i < 15; i++) fq.push_back(basic[i]);
        send_fq(1'b1);
        chk_writes("thr", 2, 32'h1000, 32'h13, 32'h1004, 32'h00100073);
        chk("thr_wcnt", word_cnt, 2);
        send_byte(8'h47, 1'b1);
        chk("thr_corerst", core_rst, 0);

        // Boundary: second word lands past the top of memory
        do_reset();
        push_load(32'h1FFC, 16'd2);
        push_word(32'h11223344);
        push_word(32'hAABBCCDD);
        send_fq(1'b0);
        chk_writes("bnd", 1, 32'h1FFC, 32'h11223344, 0, 0);
        chk("bnd_err", err_flag, 1);
        chk("bnd_wcnt", word_cnt, 1);
        push_load(32'h100, 16'd1);
        push_word(32'hDEADBEEF);
        send_fq(1'b0);
        chk_writes("bnd_next", 2, 32'h1FFC, 32'h11223344, 32'h100, 32'hDEADBEEF);
        chk("bnd_next_wcnt", word_cnt, 2);

        // Protocol: unknown byte in IDLE
        do_reset();
        send_byte(8'h00, 1'b0);
        chk("bad_byte_err", err_flag, 1);
        repeat (2) @(posedge clk);
        #1;
        chk("bad_byte_nowr", wa_q.size(), 0);

        // Protocol: misaligned base is forced down to word alignment
        do_reset();
        push_load(32'h1002, 16'd1);
        push_word(32'h01020304);
        send_fq(1'b0);
        chk("misalign_err", err_flag, 1);
        chk_writes("misalign", 1, 32'h1000, 32'h01020304, 0, 0);

        // Protocol: LEN=0 returns to IDLE without writing; GO then proves IDLE
        do_reset();
        push_load(32'h400, 16'd0);
        send_fq(1'b0);
        chk("len0_nowr", wa_q.size(), 0);
        chk("len0_err", err_flag, 0);
        send_byte(8'h47, 1'b0);
        chk("len0_go", core_rst, 0);

        // Reset in the middle of a word
        do_reset();
        push_load(32'h200, 16'd2);
        push_word(32'h55667788);
        fq.push_back(8'hEE);
        fq.push_back(8'hFF);
        send_fq(1'b0);
        chk("mid_pre_wcnt", word_cnt, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rxready", rx_ready, 0);
        chk("mid_addr", wr_addr, 0);
        chk("mid_data", wr_data, 0);
        chk("mid_corerst", core_rst, 1);
        chk("mid_wcnt", word_cnt, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        wa_q.delete();
        wd_q.delete();
        push_load(32'h300, 16'd1);
        push_word(32'hCAFEF00D);
        send_fq(1'b0);
        chk_writes("mid_fresh", 1, 32'h300, 32'hCAFEF00D, 0, 0);
        chk("mid_fresh_wcnt", word_cnt, 1);
        chk("mid_fresh_err", err_flag, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
